// File: rtl/st_event_gen_pkg.sv
// State encodings, parameter defaults and the press-qualification helper
// shared by the mode state machine's event front-end.
`ifndef ST_STATE_DEFS
`define ST_STATE_DEFS
`define ST_RST    3'd0
`define ST_STOP   3'd1
`define ST_SLEEP  3'd2
`define ST_LIGHT  3'd3
`define ST_DRAW   3'd4
`define ST_WRITE  3'd5
`define ST_ERASE  3'd6
`define ST_COLOR  3'd7
`define ST_DEBOUNCE_DEFAULT   1_000_000
`define ST_RST_CYCLES_DEFAULT 65_536
`endif

package st_event_gen_pkg;

   localparam int unsigned ST_W               = 3;
   localparam int unsigned DEBOUNCE_DEFAULT   = `ST_DEBOUNCE_DEFAULT;
   localparam int unsigned RST_CYCLES_DEFAULT = `ST_RST_CYCLES_DEFAULT;
   localparam int unsigned CNT_W_DEFAULT      = 20;

   typedef enum logic [ST_W-1:0] {
      ST_RST   = `ST_RST,
      ST_STOP  = `ST_STOP,
      ST_SLEEP = `ST_SLEEP,
      ST_LIGHT = `ST_LIGHT,
      ST_DRAW  = `ST_DRAW,
      ST_WRITE = `ST_WRITE,
      ST_ERASE = `ST_ERASE,
      ST_COLOR = `ST_COLOR
   } st_state_e;

   // States in which a debounced press is forwarded to the state machine.
   function automatic logic press_allowed(input logic [ST_W-1:0] st);
      logic allowed;
      allowed = 1'b0;
      case (st)
         `ST_SLEEP, `ST_LIGHT, `ST_DRAW,
         `ST_WRITE, `ST_ERASE, `ST_COLOR: allowed = 1'b1;
         default:                         allowed = 1'b0;
      endcase
      return allowed;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// Button conditioner: 2-FF synchroniser, consecutive-mismatch debounce and
// a one-cycle rise pulse coincident with the debounced level going high.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic level,
   output logic rise
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             level_q;
   logic             level_d;
   logic             rise_q;
   logic             rise_d;

   // Accept the synchronised level only after an unbroken run of mismatches.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      if (sync2_q == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d   = '0;
         level_d = sync2_q;
         rise_d  = sync2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
      end else begin
         sync1_q <= btn;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;

endmodule

// File: rtl/st_event_gen.sv
// Event front-end for the mode state machine: qualified press pulses from the
// mode button and the reset-period-complete flag while the machine sits in RST.
module st_event_gen
   import st_event_gen_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   parameter int unsigned RST_CYCLES      = RST_CYCLES_DEFAULT,
   parameter int unsigned CNT_W           = CNT_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            btn,
   input  logic [ST_W-1:0] state,
   output logic            state_change,
   output logic            rst_ok,
   output logic            key_level
);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_CYCLES);

   logic             deb_level;
   logic             deb_rise;
   logic             state_change_q;
   logic             state_change_d;
   logic [CNT_W-1:0] rcnt_q;
   logic [CNT_W-1:0] rcnt_d;
   logic             rst_ok_q;
   logic             rst_ok_d;

   key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
   ) u_debounce (
      .clk   (clk),
      .rst_n (rst_n),
      .btn   (btn),
      .level (deb_level),
      .rise  (deb_rise)
   );

   // Presses arriving while in RST or STOP are dropped rather than held.
   always_comb begin
      state_change_d = deb_rise & press_allowed(state);
   end

   // Init timer saturates so the flag stays up for as long as RST is held.
   always_comb begin
      rcnt_d   = '0;
      rst_ok_d = 1'b0;
      if (state == `ST_RST) begin
         rcnt_d   = (rcnt_q == RST_LAST) ? rcnt_q : rcnt_q + CNT_W'(1);
         rst_ok_d = (rcnt_d == RST_LAST);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_change_q <= 1'b0;
         rcnt_q         <= '0;
         rst_ok_q       <= 1'b0;
      end else begin
         state_change_q <= state_change_d;
         rcnt_q         <= rcnt_d;
         rst_ok_q       <= rst_ok_d;
      end
   end

   assign state_change = state_change_q;
   assign rst_ok       = rst_ok_q;
   assign key_level    = deb_level;

endmodule
